// File: rtl/morse_pkg.sv
// morse_pkg: Morse FSM states, unit thresholds and ASCII constants shared by the Morse key decoder.
package morse_pkg;
  typedef enum logic [1:0] {IDLE, MARK, GAP, WORD} state_t;
  localparam logic [2:0] DOT_MAX_UNITS  = 3'd1;
  localparam logic [2:0] LETTER_GAP     = 3'd2;
  localparam logic [2:0] WORD_GAP       = 3'd5;
  localparam logic [2:0] MAX_SYMBOL_LEN = 3'd6;
  localparam logic [7:0] ASCII_SPACE    = 8'h20;
  localparam logic [7:0] ASCII_ERR      = 8'h3F;
endpackage

// File: rtl/morse_lut.sv
// morse_lut: maps a {len,code} Morse symbol (dot=0, dash=1, first element most significant) to ASCII.
module morse_lut
  import morse_pkg::*;
(
  input  logic [2:0] len,
  input  logic [5:0] code,
  output logic       valid,
  output logic [7:0] ascii
);
  always_comb begin
    ascii = ASCII_ERR;
    case ({len, code})
      {3'd1, 6'b000000}: ascii = "E";
      {3'd1, 6'b000001}: ascii = "T";
      {3'd2, 6'b000000}: ascii = "I";
      {3'd2, 6'b000001}: ascii = "A";
      {3'd2, 6'b000010}: ascii = "N";
      {3'd2, 6'b000011}: ascii = "M";
      {3'd3, 6'b000000}: ascii = "S";
      {3'd3, 6'b000001}: ascii = "U";
      {3'd3, 6'b000010}: ascii = "R";
      {3'd3, 6'b000011}: ascii = "W";
      {3'd3, 6'b000100}: ascii = "D";
      {3'd3, 6'b000101}: ascii = "K";
      {3'd3, 6'b000110}: ascii = "G";
      {3'd3, 6'b000111}: ascii = "O";
      {3'd4, 6'b000000}: ascii = "H";
      {3'd4, 6'b000001}: ascii = "V";
      {3'd4, 6'b000010}: ascii = "F";
      {3'd4, 6'b000100}: ascii = "L";
      {3'd4, 6'b000110}: ascii = "P";
      {3'd4, 6'b000111}: ascii = "J";
      {3'd4, 6'b001000}: ascii = "B";
      {3'd4, 6'b001001}: ascii = "X";
      {3'd4, 6'b001010}: ascii = "C";
      {3'd4, 6'b001011}: ascii = "Y";
      {3'd4, 6'b001100}: ascii = "Z";
      {3'd4, 6'b001101}: ascii = "Q";
      {3'd5, 6'b011111}: ascii = "0";
      {3'd5, 6'b001111}: ascii = "1";
      {3'd5, 6'b000111}: ascii = "2";
      {3'd5, 6'b000011}: ascii = "3";
      {3'd5, 6'b000001}: ascii = "4";
      {3'd5, 6'b000000}: ascii = "5";
      {3'd5, 6'b010000}: ascii = "6";
      {3'd5, 6'b011000}: ascii = "7";
      {3'd5, 6'b011100}: ascii = "8";
      {3'd5, 6'b011110}: ascii = "9";
      default:           ascii = ASCII_ERR;
    endcase
  end
  assign valid = ascii != ASCII_ERR;
endmodule

// File: rtl/morse_key_decoder.sv
// morse_key_decoder: debounces a hand key, times marks/spaces in dot units and emits ASCII per letter/word gap.
module morse_key_decoder
  import morse_pkg::*;
#(
  parameter logic [23:0] DOT_TICKS      = 24'd10_000_000,
  parameter logic [15:0] DEBOUNCE_TICKS = 16'd1_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       morse_in,
  output logic [7:0] char_out,
  output logic       char_strb,
  output logic       decode_err,
  output logic       busy
);
  logic s0, s1, key_db, flip, dash, ovf, valid;
  logic [15:0] db_cnt;
  logic [23:0] tick_cnt;
  logic [2:0] unit_cnt, len;
  logic [5:0] code;
  logic [7:0] ascii;
  state_t state;
  // flip marks the cycle key_db toggles, so the FSM still sees the pre-clear unit count
  assign flip = (s1 != key_db) && (db_cnt == DEBOUNCE_TICKS);
  assign dash = unit_cnt > DOT_MAX_UNITS;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s0 <= 1'b0;
      s1 <= 1'b0;
      key_db <= 1'b0;
      db_cnt <= '0;
    end else begin
      s0 <= morse_in;
      s1 <= s0;
      db_cnt <= (s1 == key_db || flip) ? '0 : db_cnt + 16'd1;
      if (flip) key_db <= s1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n || flip) begin
      tick_cnt <= '0;
      unit_cnt <= '0;
    end else if (tick_cnt == DOT_TICKS - 24'd1) begin
      tick_cnt <= '0;
      unit_cnt <= unit_cnt + {2'b0, unit_cnt != 3'd7};
    end else begin
      tick_cnt <= tick_cnt + 24'd1;
    end
  end
  morse_lut u_lut (
    .len  (len),
    .code (code),
    .valid(valid),
    .ascii(ascii)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      code <= '0;
      len <= '0;
      ovf <= 1'b0;
      char_out <= 8'h00;
      char_strb <= 1'b0;
      decode_err <= 1'b0;
      busy <= 1'b0;
    end else begin
      char_strb <= 1'b0;
      decode_err <= 1'b0;
      case (state)
        IDLE: if (key_db) begin
          state <= MARK;
          busy <= 1'b1;
        end
        MARK: if (flip) begin
          if (len == MAX_SYMBOL_LEN) ovf <= 1'b1;
          else begin
            code <= {code[4:0], dash};
            len <= len + 3'd1;
          end
          state <= GAP;
        end
        GAP: if (unit_cnt == LETTER_GAP) begin
          char_out <= (valid && !ovf) ? ascii : ASCII_ERR;
          decode_err <= !valid || ovf;
          char_strb <= 1'b1;
          busy <= 1'b0;
          code <= '0;
          len <= '0;
          ovf <= 1'b0;
          state <= WORD;
        end else if (key_db) state <= MARK;
        WORD: if (unit_cnt == WORD_GAP) begin
          char_out <= ASCII_SPACE;
          char_strb <= 1'b1;
          state <= IDLE;
        end else if (key_db) begin
          state <= MARK;
          busy <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
